// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between
// NUM_REQ requesters, with a one-deep tagged response register.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [4*NUM_REQ-1:0]    req_op_i,
  input  logic [32*NUM_REQ-1:0]   req_src1_i,
  input  logic [32*NUM_REQ-1:0]   req_src2_i,
  output logic [3:0]              alu_op_o,
  output logic [31:0]             alu_src1_o,
  output logic [31:0]             alu_src2_o,
  input  logic [31:0]             alu_result_i,
  input  logic                    alu_zero_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic [31:0]             rsp_result_o,
  output logic                    rsp_zero_o
);

  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_result_q, rsp_result_d;
  logic            rsp_zero_q, rsp_zero_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  logic            can_issue;
  logic            found;
  logic            grant;
  int              win;

  // Search upward from ptr (wrapping) for the first valid requester.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Grant only when the response slot is free or draining, never in reset.
  always_comb begin
    can_issue = !rsp_valid_q || rsp_ready_i;
    grant     = found && can_issue && !rst_i;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready_o[k] = grant && (win == k);
    end
  end

  // Route the winner's fields to the ALU; idle drive is all zeros.
  always_comb begin
    alu_op_o   = 4'h0;
    alu_src1_o = 32'h0;
    alu_src2_o = 32'h0;
    if (grant) begin
      alu_op_o   = req_op_i[4*win +: 4];
      alu_src1_o = req_src1_i[32*win +: 32];
      alu_src2_o = req_src2_i[32*win +: 32];
    end
  end

  // Response register and pointer next-state: accept wins over drain.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    ptr_d        = ptr_q;
    if (grant) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = ID_W'(win);
      rsp_result_d = alu_result_i;
      rsp_zero_d   = alu_zero_i;
      ptr_d        = (win == NUM_REQ-1) ? '0 : ID_W'(win + 1);
    end else if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= 32'h0;
      rsp_zero_q   <= 1'b0;
      ptr_q        <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      ptr_q        <= ptr_d;
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_zero_o   = rsp_zero_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter that shares the single combinational `alu` between `NUM_REQ` requesters (for example the integer pipe and a multi-cycle helper unit). It grants one requester per cycle, drives the winner's opcode and operands onto the ALU, and captures the result and zero flag in a one-deep response register. The response register is tagged with the requester ID. The block sits between the requesters and the `alu` instance; the ALU itself stays purely combinational.

## Interface
- `NUM_REQ`, 2, number of requesters; legal range 2..8.
- `ID_W`, `$clog2(NUM_REQ)`, width of the requester ID; minimum 1.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  NUM_REQ  per-requester request valid.
- `req_ready_o`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_op_i`  in  4*NUM_REQ  opcode; requester k in bits [4k+3:4k].
- `req_src1_i`  in  32*NUM_REQ  operand 1; requester k in bits [32k+31:32k].
- `req_src2_i`  in  32*NUM_REQ  operand 2, same packing as `req_src1_i`.
- `alu_op_o`  out  4  opcode to the ALU.
- `alu_src1_o`  out  32  operand 1 to the ALU.
- `alu_src2_o`  out  32  operand 2 to the ALU.
- `alu_result_i`  in  32  ALU result.
- `alu_zero_i`  in  1  ALU zero flag.
- `rsp_valid_o`  out  1  response register holds a result.
- `rsp_ready_i`  in  1  consumer accepts the response.
- `rsp_id_o`  out  ID_W  index of the requester that owns the response.
- `rsp_result_o`  out  32  registered ALU result.
- `rsp_zero_o`  out  1  registered zero flag.

## Operation
- **State:**
  - response register (`rsp_valid`, id, result, zero);
  - round-robin pointer `ptr`, range 0..NUM_REQ-1.
- **Grant enable:** `can_issue = !rsp_valid_o || rsp_ready_i`.
- **Arbitration (combinational):**
  - When `can_issue` is high, the search starts at `ptr` and proceeds upward modulo NUM_REQ.
  - The first k with `req_valid_i[k]` high wins.
  - `req_ready_o[k] = 1` for the winner only; all other bits are 0.
  - No winner, or `can_issue` low: `req_ready_o = 0`.
- **Accept:** `req_valid_i[k] && req_ready_o[k]`.
  - Requesters must not make `req_valid_i` depend on `req_ready_o`.
  - A requester holds its op and operands stable while valid and not accepted.
- **ALU drive:**
  - While a winner exists, `alu_op_o`, `alu_src1_o` and `alu_src2_o` carry the winner's fields.
  - Otherwise all three are driven to 0.
- **On an accept edge:**
  - load `rsp_id_o = k`;
  - load `rsp_result_o = alu_result_i` and `rsp_zero_o = alu_zero_i`;
  - set `rsp_valid_o = 1`;
  - set `ptr = (k+1) mod NUM_REQ`.
- **Drain without accept:** `rsp_valid_o && rsp_ready_i` with no new accept clears `rsp_valid_o`. Payload fields keep their last value.
- **Simultaneous drain and accept:** the new result replaces the old one in the same edge and `rsp_valid_o` stays 1. This gives full throughput of one operation per cycle.
- **Stall:** while `rsp_valid_o && !rsp_ready_i`:
  - the response fields are held stable;
  - `ptr` is unchanged;
  - no grant is issued.
- **Idle:** `ptr` changes only on an accept.
- **Opcode handling:** opcodes are passed through unchecked. The ALU returns 0 for undefined opcodes, and that result is returned normally.

## Timing
- **Reset values:**
  - `rsp_valid_o = 0`;
  - `rsp_id_o = 0`, `rsp_result_o = 0`, `rsp_zero_o = 0`;
  - `ptr = 0`.
- **During reset:**
  - `req_ready_o` is forced to 0 while `rst_i` is high;
  - any pending response is discarded;
  - a request presented in the reset cycle is not accepted.
- **Latency:** request accepted in cycle N → `rsp_valid_o` high in cycle N+1 with the result.
- **Ready path:** `req_ready_o` is combinational from `req_valid_i`, `rsp_valid_o`, `rsp_ready_i` and `ptr`.
- **ALU path:** the ALU outputs are combinational from the grant; the result is registered at the end of the same cycle.
- **Fairness:** with all requesters continuously valid and `rsp_ready_i = 1`, grants rotate 0,1,…,NUM_REQ-1,0,… A requester waits at most NUM_REQ-1 grants.

## Test plan
1. **Single request:** reset, then requester 0 issues ADD 5+7 → `req_ready_o = 01` that cycle. Next cycle: `rsp_valid_o = 1`, id 0, result 12, zero 0.
2. **Rotation (NUM_REQ=2):** both requesters hold valid with SUB 9-9 and OR 0|0, `rsp_ready_i` held high → grant order 0,1,0,1. Every response has zero = 1 and ids alternate.
3. **Backpressure:** hold `rsp_ready_i = 0` after one accept.
   - Required: `req_ready_o = 0` and response fields stable for 5 cycles.
   - Raise `rsp_ready_i` → the next grant goes to the requester after the last winner.
4. **Back-to-back:** requester 1 issues AND 0xF0F0_F0F0 & 0xFF00_FF00 → result 0xF000_F000. In the same cycle the previous response drains and a new request is accepted → `rsp_valid_o` stays high with no bubble.
5. **Reset mid-operation:** with a response pending and `rsp_ready_i = 0`, assert `rst_i` for 1 cycle.
   - Required: `rsp_valid_o = 0`, `req_ready_o = 0` during reset, `ptr = 0`.
   - After reset, requester 0 wins a simultaneous request.
6. **Idle drive and undefined opcode:** with no valid requests, `alu_op_o`, `alu_src1_o` and `alu_src2_o` are all 0. An undefined opcode 4'hF with operands 3,4 → result 0, zero 1.
